// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB request arbiter.
// Arbitration policy is chosen in apb_req_arbiter via the APB_ARB_RR_EN macro.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic APB_RD = 1'b1;
    localparam logic APB_WR = 1'b0;

endpackage

// File: rtl/apb_arb_pick.sv
// Combinational requester picker: the first set request at or after base,
// wrapping modulo NREQ, returned as a one-hot vector and as an index.
module apb_arb_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] base,
    output logic [NREQ-1:0]  onehot,
    output logic [IDX_W-1:0] index
);

    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] pos;

    always_comb begin
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        sum    = '0;
        pos    = '0;
        for (int k = 0; k < NREQ; k++) begin
            // one guard bit lets a non-power-of-two NREQ wrap correctly
            sum = {1'b0, base} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NREQ)) begin
                sum = sum - (IDX_W+1)'(NREQ);
            end
            pos = sum[IDX_W-1:0];
            if (!found && req[pos]) begin
                found       = 1'b1;
                onehot[pos] = 1'b1;
                index       = pos;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one apb_protocol master between NREQ requesters, one transaction at a time.
// Define APB_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 8,
    parameter int XFER_CYCLES = 2
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     transfer,
    output logic                     READ_WRITE,
    output logic [ADDR_W-1:0]        apb_write_paddr,
    output logic [DATA_W-1:0]        apb_write_data,
    output logic [ADDR_W-1:0]        apb_read_paddr,
    input  logic                     PSLVERR,
    input  logic [DATA_W-1:0]        apb_read_data_out
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(XFER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XFER_CYCLES - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [NREQ-1:0]  owner;
    logic             cmd_write;

    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] pick_idx;
    logic [NREQ-1:0]  pick_hot;
    logic             sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    apb_arb_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
        .req    (req_valid),
        .base   (base),
        .onehot (pick_hot),
        .index  (pick_idx)
    );

`ifdef APB_ARB_RR_EN
    logic [IDX_W-1:0] ptr;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ptr <= '0;
        end else if (state == IDLE && |req_valid) begin
            ptr <= (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    assign base = ptr;
`else
    assign base = '0;
`endif

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_hot[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|req_valid) state_nx = XFER;
            XFER:    if (cnt == CNT_LAST) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt             <= '0;
            owner           <= '0;
            cmd_write       <= 1'b0;
            req_ready       <= '0;
            rsp_valid       <= '0;
            rsp_rdata       <= '0;
            rsp_err         <= 1'b0;
            busy            <= 1'b0;
            grant_id        <= '0;
            transfer        <= 1'b0;
            READ_WRITE      <= 1'b0;
            apb_write_paddr <= '0;
            apb_write_data  <= '0;
            apb_read_paddr  <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        owner           <= pick_hot;
                        req_ready       <= pick_hot;
                        grant_id        <= pick_idx;
                        cmd_write       <= sel_write;
                        cnt             <= '0;
                        busy            <= 1'b1;
                        transfer        <= 1'b1;
                        READ_WRITE      <= sel_write ? APB_WR : APB_RD;
                        apb_write_paddr <= sel_write ? sel_addr  : '0;
                        apb_write_data  <= sel_write ? sel_wdata : '0;
                        apb_read_paddr  <= sel_write ? '0 : sel_addr;
                    end
                end
                XFER: begin
                    if (cnt == CNT_LAST) begin
                        // last access cycle: master response is valid on this edge
                        transfer        <= 1'b0;
                        READ_WRITE      <= 1'b0;
                        apb_write_paddr <= '0;
                        apb_write_data  <= '0;
                        apb_read_paddr  <= '0;
                        rsp_valid       <= owner;
                        rsp_rdata       <= cmd_write ? '0 : apb_read_data_out;
                        rsp_err         <= PSLVERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: transaction-schedule model with a
// per-cycle compare, a small APB slave stand-in, and directed scenarios.
module tb_apb_req_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int XC     = 2;

    logic                     PCLK = 1'b0;
    logic                     PRESET = 1'b1;
    logic [NREQ-1:0]          req_valid = '0;
    logic [NREQ-1:0]          req_write = '0;
    logic [NREQ*ADDR_W-1:0]   req_addr = '0;
    logic [NREQ*DATA_W-1:0]   req_wdata = '0;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ-1:0]          rsp_valid;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     rsp_err;
    logic                     busy;
    logic [1:0]               grant_id;
    logic                     transfer;
    logic                     READ_WRITE;
    logic [ADDR_W-1:0]        apb_write_paddr;
    logic [DATA_W-1:0]        apb_write_data;
    logic [ADDR_W-1:0]        apb_read_paddr;
    logic                     PSLVERR = 1'b0;
    logic [DATA_W-1:0]        apb_read_data_out = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    apb_req_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .XFER_CYCLES(XC)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .grant_id(grant_id), .transfer(transfer), .READ_WRITE(READ_WRITE),
        .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
        .apb_read_paddr(apb_read_paddr), .PSLVERR(PSLVERR), .apb_read_data_out(apb_read_data_out)
    );

    initial forever #5 PCLK = ~PCLK;
    initial forever begin @(posedge PCLK); cyc++; end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic bitv(input logic [NREQ-1:0] v, input int i);
        logic [NREQ-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        return NREQ'(1) << i;
    endfunction

    // spec rule: first requester at or after start, wrapping
    function automatic int winner(input logic [NREQ-1:0] v, input int start);
        for (int k = 0; k < NREQ; k++) begin
            if (bitv(v, (start + k) % NREQ)) return (start + k) % NREQ;
        end
        return 0;
    endfunction

    // APB slave stand-in: response is only correct on the last access cycle
    logic [7:0] mem [0:511];
    logic       wrt [0:511];
    initial begin
        int k;
        logic [8:0] a;
        logic err;
        k = 0;
        for (int i = 0; i < 512; i++) begin mem[i] = 8'h00; wrt[i] = 1'b0; end
        forever begin
            @(negedge PCLK);
            if (transfer) k++; else k = 0;
            if (transfer) begin
                a   = READ_WRITE ? apb_read_paddr : apb_write_paddr;
                err = (a[7:6] != 2'b00) || (READ_WRITE && !wrt[a]);
                if (k == XC) begin
                    PSLVERR = err;
                    apb_read_data_out = (READ_WRITE && !err) ? mem[a] : 8'h00;
                    if (!READ_WRITE && !err) begin mem[a] = apb_write_data; wrt[a] = 1'b1; end
                end else begin
                    PSLVERR = ~err;
                    apb_read_data_out = 8'hEE;
                end
            end else begin
                PSLVERR = 1'b0;
                apb_read_data_out = 8'h00;
            end
        end
    end

    // Model: arbiter is free at cycle free_at; a grant sampled in cycle s
    // yields ready at s+1, transfer s+1..s+XC, response at s+XC+1.
    initial begin
        int p, free_at, s, g, gid, ptr;
        logic armed, rst, m_w, e_err, pe, ex_x, ex_r;
        logic [NREQ-1:0] rv, rw;
        logic [NREQ*ADDR_W-1:0] ra;
        logic [NREQ*DATA_W-1:0] rdv;
        logic [8:0] m_a;
        logic [7:0] m_d, e_rd, pd;
        p = 0; free_at = 0; s = -1; g = 0; gid = 0; ptr = 0; armed = 1'b0;
        m_w = 1'b0; m_a = '0; m_d = '0; e_rd = '0; e_err = 1'b0;
        forever begin
            @(posedge PCLK);
            p++;
            rst = PRESET; rv = req_valid; rw = req_write; ra = req_addr; rdv = req_wdata;
            pe = PSLVERR; pd = apb_read_data_out;
            if (rst) begin
                armed = 1'b1; s = -1; gid = 0; ptr = 0; free_at = p;
            end else if (armed) begin
                if (s >= 0 && p - 1 == s + XC) begin
                    e_rd = m_w ? 8'h00 : pd;
                    e_err = pe;
                end
                if (p - 1 == free_at) begin
                    if (rv != 0) begin
                        g = winner(rv, ptr);
                        s = p - 1;
                        m_w = bitv(rw, g);
                        m_a = ADDR_W'(ra >> (g * ADDR_W));
                        m_d = DATA_W'(rdv >> (g * DATA_W));
                        gid = g;
`ifdef APB_ARB_RR_EN
                        ptr = (g + 1) % NREQ;
`endif
                        free_at = s + XC + 2;
                    end else begin
                        free_at = p;
                    end
                end
            end
            #2;
            if (armed) begin
                ex_x = (s >= 0) && (p >= s + 1) && (p <= s + XC);
                ex_r = (s >= 0) && (p == s + XC + 1);
                chk("req_ready", req_ready, (s >= 0 && p == s + 1) ? onehot(g) : '0);
                chk("rsp_valid", rsp_valid, ex_r ? onehot(g) : '0);
                chk("transfer", transfer, ex_x);
                chk("busy", busy, ex_x || ex_r);
                chk("grant_id", grant_id, gid);
                chk("READ_WRITE", READ_WRITE, ex_x && !m_w);
                chk("write_paddr", apb_write_paddr, (ex_x && m_w) ? m_a : 9'h000);
                chk("write_data", apb_write_data, (ex_x && m_w) ? m_d : 8'h00);
                chk("read_paddr", apb_read_paddr, (ex_x && !m_w) ? m_a : 9'h000);
                if (ex_r) begin
                    chk("rsp_rdata", rsp_rdata, e_rd);
                    chk("rsp_err", rsp_err, e_err);
                end
                if (rst) begin
                    chk("rst_rdata", rsp_rdata, 8'h00);
                    chk("rst_err", rsp_err, 1'b0);
                end
            end
        end
    end

    typedef struct {
        int req_c; int rdy_c; int rsp_c;
        logic rw; logic [8:0] wpa; logic [7:0] wd; logic [8:0] rpa;
        logic [7:0] rd; logic err; logic ok;
    } res_t;

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [8:0] a, input logic [7:0] d);
        logic [NREQ-1:0] m;
        logic [NREQ*ADDR_W-1:0] am, av;
        logic [NREQ*DATA_W-1:0] dm, dv;
        m = onehot(i);
        req_valid = v ? (req_valid | m) : (req_valid & ~m);
        req_write = w ? (req_write | m) : (req_write & ~m);
        am = '0; am[ADDR_W-1:0] = '1; av = '0; av[ADDR_W-1:0] = a;
        dm = '0; dm[DATA_W-1:0] = '1; dv = '0; dv[DATA_W-1:0] = d;
        req_addr  = (req_addr  & ~(am << (i * ADDR_W))) | (av << (i * ADDR_W));
        req_wdata = (req_wdata & ~(dm << (i * DATA_W))) | (dv << (i * DATA_W));
    endtask

    task automatic do_req(input int i, input logic w, input logic [8:0] a,
                          input logic [7:0] d, output res_t r);
        int n;
        r = '{default: 0};
        @(negedge PCLK);
        set_req(i, 1'b1, w, a, d);
        r.req_c = cyc;
        n = 0;
        while (!bitv(req_ready, i) && n < 60) begin @(negedge PCLK); n++; end
        if (!bitv(req_ready, i)) begin
            chk("ready_timeout", 32'd0, 32'd1);
            set_req(i, 1'b0, w, a, d);
            return;
        end
        r.rdy_c = cyc; r.rw = READ_WRITE; r.wpa = apb_write_paddr;
        r.wd = apb_write_data; r.rpa = apb_read_paddr;
        set_req(i, 1'b0, w, a, d);
        n = 0;
        while (!bitv(rsp_valid, i) && n < 60) begin @(negedge PCLK); n++; end
        if (!bitv(rsp_valid, i)) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        r.rsp_c = cyc; r.rd = rsp_rdata; r.err = rsp_err; r.ok = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        res_t r;
        int n, seen, extra;
        int got[$];
`ifdef APB_ARB_RR_EN
        int exp_g[$] = '{0, 1, 2, 3, 0};
`else
        int exp_g[$] = '{0, 0, 0};
`endif
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        repeat (2) @(negedge PCLK);

        // single write from requester 0
        do_req(0, 1'b1, 9'h003, 8'h06, r);
        chk("w_ok", r.ok, 1'b1);
        chk("w_ready_lat", r.rdy_c - r.req_c, 1);
        chk("w_rsp_lat", r.rsp_c - r.rdy_c, 2);
        chk("w_paddr", r.wpa, 9'h003);
        chk("w_data", r.wd, 8'h06);
        chk("w_rw", r.rw, 1'b0);
        chk("w_err", r.err, 1'b0);
        chk("w_rdata", r.rd, 8'h00);

        // write then read slave2 address from requester 1
        do_req(1, 1'b1, 9'h105, 8'h05, r);
        chk("w2_err", r.err, 1'b0);
        do_req(1, 1'b0, 9'h105, 8'h00, r);
        chk("r_rw", r.rw, 1'b1);
        chk("r_paddr", r.rpa, 9'h105);
        chk("r_wpaddr", r.wpa, 9'h000);
        chk("r_rdata", r.rd, 8'h05);
        chk("r_err", r.err, 1'b0);

        // error responses: unwritten and out-of-range reads
        do_req(2, 1'b0, 9'h02D, 8'h00, r);
        chk("unwr_err", r.err, 1'b1);
        chk("unwr_rdata", r.rd, 8'h00);
        do_req(3, 1'b0, 9'h1C0, 8'h00, r);
        chk("oor_err", r.err, 1'b1);

        // requester 2 drops valid right after its accept: exactly one grant
        do_req(2, 1'b0, 9'h105, 8'h00, r);
        chk("drop_ok", r.ok, 1'b1);
        chk("drop_rdata", r.rd, 8'h05);
        extra = 0;
        repeat (12) begin @(negedge PCLK); if (bitv(req_ready, 2)) extra++; end
        chk("drop_no_regrant", extra, 0);

        // reset in the middle of a transfer
        @(negedge PCLK);
        set_req(0, 1'b1, 1'b1, 9'h010, 8'h77);
        n = 0;
        while (!bitv(req_ready, 0) && n < 60) begin @(negedge PCLK); n++; end
        chk("rst_seq_ready", bitv(req_ready, 0), 1'b1);
        set_req(0, 1'b0, 1'b1, 9'h010, 8'h77);
        @(negedge PCLK);
        PRESET = 1'b1;
        seen = 0;
        @(negedge PCLK);
        chk("rst_transfer", transfer, 1'b0);
        chk("rst_busy", busy, 1'b0);
        if (rsp_valid != 0) seen++;
        @(negedge PCLK);
        if (rsp_valid != 0) seen++;
        PRESET = 1'b0;
        repeat (4) begin @(negedge PCLK); if (rsp_valid != 0) seen++; end
        chk("rst_no_rsp", seen, 0);
        chk("rst_idle_transfer", transfer, 1'b0);

        // all four requesters hold valid
        @(negedge PCLK);
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 9'h105, 8'h00);
        n = 0;
        while (got.size() < exp_g.size() && n < 80) begin
            @(negedge PCLK);
            n++;
            for (int i = 0; i < NREQ; i++) if (bitv(req_ready, i)) got.push_back(i);
        end
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 9'h105, 8'h00);
        chk("arb_count", got.size(), exp_g.size());
        for (int i = 0; i < exp_g.size() && i < got.size(); i++) chk("arb_order", got[i], exp_g[i]);
        repeat (8) @(negedge PCLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
